// File: rtl/key_unlock_sequencer.sv
// key_unlock_sequencer: serially loads an unlock key, applies it to a key-locked core and sequences the core's reset release.
// Define KEY_PARITY_EN to expect a trailing even-parity bit after the key and to reject the key when that bit mismatches.
module key_unlock_sequencer #(
    parameter int KEY_W        = 8,
    parameter int RST_CYCLES   = 4,
    parameter int LOAD_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    input  logic             key_bit,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic             lock_req,
    output logic [KEY_W-1:0] key_out,
    output logic             core_rst,
    output logic             core_run,
    output logic             busy,
    output logic             load_done,
    output logic             err
);
`ifdef KEY_PARITY_EN
    localparam int NB = KEY_W + 1;
`else
    localparam int NB = KEY_W;
`endif
    localparam int TMAX = LOAD_TIMEOUT > RST_CYCLES ? LOAD_TIMEOUT : RST_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int CW   = $clog2(NB + 1);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD_RST, RUN} state_e;

    state_e           state_q, state_d;
    logic [KEY_W-1:0] key_out_q, key_out_d, shadow_q, shadow_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic             load_done_q, load_done_d, err_q, err_d;
    logic             accept;

    assign accept = key_valid && state_q == LOAD;

    always_comb begin
        state_d     = state_q;
        key_out_d   = key_out_q;
        shadow_d    = shadow_q;
        bit_cnt_d   = bit_cnt_q;
        tmr_d       = tmr_q;
        err_d       = err_q;
        load_done_d = 1'b0;
        case (state_q)
            IDLE, RUN: begin
                if (load_start) begin
                    state_d   = LOAD;
                    key_out_d = '0;
                    shadow_d  = '0;
                    bit_cnt_d = '0;
                    tmr_d     = '0;
                    err_d     = 1'b0;
                end
            end
            LOAD: begin
                if (accept) begin
                    shadow_d  = shadow_q | (KEY_W'(key_bit) << bit_cnt_q);
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    tmr_d     = '0;
                    if (bit_cnt_q == CW'(NB - 1)) begin
`ifdef KEY_PARITY_EN
                        // Even parity: the trailing bit must equal the XOR of all key bits.
                        if ((^shadow_q) == key_bit) begin
                            state_d   = HOLD_RST;
                            key_out_d = shadow_q;
                        end else begin
                            state_d = IDLE;
                            err_d   = 1'b1;
                        end
`else
                        state_d   = HOLD_RST;
                        key_out_d = shadow_d;
`endif
                    end
                end else if (tmr_q == TW'(LOAD_TIMEOUT - 1)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            HOLD_RST: begin
                if (tmr_q == TW'(RST_CYCLES - 1)) begin
                    state_d     = RUN;
                    tmr_d       = '0;
                    load_done_d = 1'b1;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Lock overrides everything decided above, but leaves the error flag alone.
        if (lock_req) begin
            state_d     = IDLE;
            key_out_d   = '0;
            shadow_d    = '0;
            bit_cnt_d   = '0;
            tmr_d       = '0;
            err_d       = err_q;
            load_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            key_out_q   <= '0;
            shadow_q    <= '0;
            bit_cnt_q   <= '0;
            tmr_q       <= '0;
            load_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_out_q   <= key_out_d;
            shadow_q    <= shadow_d;
            bit_cnt_q   <= bit_cnt_d;
            tmr_q       <= tmr_d;
            load_done_q <= load_done_d;
            err_q       <= err_d;
        end
    end

    assign key_ready = state_q == LOAD;
    assign busy      = state_q == LOAD || state_q == HOLD_RST;
    assign core_rst  = state_q != RUN;
    assign core_run  = state_q == RUN;
    assign key_out   = key_out_q;
    assign load_done = load_done_q;
    assign err       = err_q;
endmodule
